seg_scan_display: RTL and testbench
===================================

# seg_scan_display

Parametrised, time-multiplexed driver for a bank of common-anode seven-segment digits. It is the general successor to the fixed four-digit scan display:
- digit count and scan rate are parameters;
- hex decode is built in;
- updates are double-buffered and applied only at frame boundaries, so the display never tears.

It also adds per-digit blanking, per-digit blinking and leading-zero suppression. It sits between score/timer logic and the board's `seg`/`an` pins.

## Interface
Parameters:
- `NUM_DIGITS`, 4: number of digits scanned (2..8).
- `TICKS_PER_DIGIT`, 8000: `clk` cycles each digit stays lit (≥2).
- `BLINK_FRAMES`, 64: completed scan frames per blink half-period (≥1).

Ports (one clock; reset is synchronous and active-high):
- `clk`  in  1  system clock.
- `reset`  in  1  synchronous, active-high reset.
- `value`  in  4·NUM_DIGITS  hex nibbles; nibble i drives digit i, and digit 0 is the rightmost.
- `blank`  in  NUM_DIGITS  per-digit force-off mask.
- `blink`  in  NUM_DIGITS  per-digit blink-enable mask.
- `lz_en`  in  1  leading-zero suppression enable.
- `load`  in  1  one-cycle strobe that captures `value`/`blank`/`blink` into the pending buffer.
- `pending`  out  1  high while a captured update has not yet been applied.
- `seg`  out  7  segment drive, active-low; `seg[0]`=a … `seg[6]`=g.
- `an`  out  NUM_DIGITS  anode enables, active-low, one-hot-low.

## Operation
- Prescaler `tick_cnt` counts 0..TICKS_PER_DIGIT-1 and wraps. When it wraps, digit index `idx` advances by one, and from NUM_DIGITS-1 it wraps to 0. The `idx` wrap is a *frame boundary*.
- Buffers:
  - `load` copies the inputs into the pending buffer and sets `pending`.
  - At a frame boundary with `pending`=1, the pending buffer copies into the active buffer and `pending` clears.
  - Rendering uses only the active buffer.
- `load` on the same cycle as a frame boundary: the new inputs go straight into the active buffer and `pending` stays 0.
- `load` while already pending: the pending buffer is overwritten and the latest load wins.
- Blink: frame counter counts 0..BLINK_FRAMES-1. On its wrap, `blink_phase` toggles. While `blink_phase`=1, digits whose active `blink` bit is set are off.
- Leading-zero suppression: with `lz_en`=1, zero nibbles from digit NUM_DIGITS-1 downward are off until the first non-zero nibble. Digit 0 is never suppressed by this rule.
- A digit is off if any of `blank`, blink, or leading-zero suppression applies. An off digit drives `seg`=7'h7F with its anode still low, which keeps the duty cycle uniform.
- Decode covers 0-F, using the standard hex glyphs (b and d lowercase).

## Timing
- `seg`/`an` are registered: they reflect the `idx` and active buffer of the previous cycle, giving one cycle of latency.
- Reset values:
  - `an`=all ones and `seg`=7'h7F (everything off);
  - `pending`=0;
  - `idx`=0, `tick_cnt`=0;
  - frame counter 0, `blink_phase`=0;
  - active and pending buffers zero, i.e. the display shows "0…0".
- On the first edge after `reset` drops, `an` goes low on bit 0. Each digit then stays lit for exactly TICKS_PER_DIGIT cycles, and a full frame is NUM_DIGITS·TICKS_PER_DIGIT cycles.
- An update applied at a frame boundary is visible on digit 0 one cycle later. Worst-case update latency from `load` is one frame plus one cycle.
- `reset` asserted mid-frame or mid-pending: the next edge forces the reset values and discards any pending update.
- `pending` rises the cycle after `load` and falls the cycle after the applying boundary.

## Structure
- Package `seg_pkg` holds:
  - the `SEG_OFF` = 7'h7F constant;
  - the 16-entry hex glyph constant array;
  - the `clog2`-derived width helpers for `idx` and the counters.
- One combinational sub-module, `hex_to_seg` (nibble → 7-bit active-low glyph), is instantiated once on the selected nibble.
- Counters, buffers, suppression logic and output registers live in the top module.

## Test plan
All scenarios use NUM_DIGITS=4, TICKS_PER_DIGIT=4, BLINK_FRAMES=2.
- **Reset/scan:** release reset → `an` cycles 1110, 1101, 1011, 0111 with each pattern held 4 cycles and a period of 16; `seg`=7'h40 ("0") throughout.
- **Double buffering:** `load` `value`=16'h12AF mid-frame → `pending`=1 and the old digits keep showing. At the next `idx` 3→0 wrap, `pending`=0, and the digits show F, A, 2, 1 with digit0 `seg`=7'h0E.
- **Same-cycle and back-to-back loads:** `load` exactly on the boundary cycle → new value applied with no `pending` pulse. Two loads (16'h1111 then 16'h2222) within one frame → only 2222 ever appears.
- **Leading zeros and blank:** `value`=16'h0050 with `lz_en`=1 → digits 3 and 2 show 7'h7F, digits 1/0 show "5"/"0". `blank`=4'b0001 → digit 0 reads 7'h7F.
- **Blink:** `blink`=4'b0010 → digit 1 alternates visible/off every 2 frames (32 cycles); other digits are unaffected.
- **Reset mid-operation:** assert `reset` while `pending`=1 → outputs all off the next cycle, the pending update is lost, and the display shows "0000" after release.

Source files
------------

// File: rtl/seg_pkg.sv
// Shared constants and width helpers for the seven-segment scan display.
package seg_pkg;

  // All segments dark (active-low drive).
  localparam logic [6:0] SEG_OFF = 7'h7F;

  // Active-low hex glyphs, bit 0 = segment a ... bit 6 = segment g; b and d are lowercase.
  localparam logic [6:0] HEX_GLYPHS [16] = '{
    7'h40, 7'h79, 7'h24, 7'h30,
    7'h19, 7'h12, 7'h02, 7'h78,
    7'h00, 7'h10, 7'h08, 7'h03,
    7'h46, 7'h21, 7'h06, 7'h0E
  };

  // Register width needed to count 0..n-1, never less than one bit.
  function automatic int unsigned cnt_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/seg_scan_display_hex_to_seg.sv
// Combinational nibble to active-low seven-segment glyph decoder.
module hex_to_seg
  import seg_pkg::*;
(
  input  logic [3:0] nibble,
  output logic [6:0] glyph_c
);

  assign glyph_c = HEX_GLYPHS[nibble];

endmodule

// File: rtl/seg_scan_display.sv
// Time-multiplexed common-anode seven-segment driver with frame-synchronous
// double-buffered updates, blanking, blinking and leading-zero suppression.
module seg_scan_display
  import seg_pkg::*;
#(
  parameter int unsigned NUM_DIGITS      = 4,
  parameter int unsigned TICKS_PER_DIGIT = 8000,
  parameter int unsigned BLINK_FRAMES    = 64
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [4*NUM_DIGITS-1:0] value,
  input  logic [NUM_DIGITS-1:0]   blank,
  input  logic [NUM_DIGITS-1:0]   blink,
  input  logic                    lz_en,
  input  logic                    load,
  output logic                    pending,
  output logic [6:0]              seg,
  output logic [NUM_DIGITS-1:0]   an
);

  localparam int unsigned IDX_W   = cnt_width(NUM_DIGITS);
  localparam int unsigned TICK_W  = cnt_width(TICKS_PER_DIGIT);
  localparam int unsigned FRAME_W = cnt_width(BLINK_FRAMES);
  localparam int unsigned VAL_W   = 4 * NUM_DIGITS;

  localparam logic [IDX_W-1:0]   LAST_IDX   = IDX_W'(NUM_DIGITS - 1);
  localparam logic [TICK_W-1:0]  LAST_TICK  = TICK_W'(TICKS_PER_DIGIT - 1);
  localparam logic [FRAME_W-1:0] LAST_FRAME = FRAME_W'(BLINK_FRAMES - 1);

  logic [TICK_W-1:0]     tick_cnt;
  logic [IDX_W-1:0]      idx;
  logic [FRAME_W-1:0]    frame_cnt;
  logic                  blink_phase;

  logic [VAL_W-1:0]      act_value;
  logic [NUM_DIGITS-1:0] act_blank;
  logic [NUM_DIGITS-1:0] act_blink;
  logic [VAL_W-1:0]      pend_value;
  logic [NUM_DIGITS-1:0] pend_blank;
  logic [NUM_DIGITS-1:0] pend_blink;

  logic                  tick_wrap_c;
  logic                  frame_end_c;
  logic [NUM_DIGITS-1:0] lz_mask_c;
  logic [3:0]            nibble_c;
  logic                  dark_c;
  logic [NUM_DIGITS-1:0] an_c;
  logic [6:0]            glyph_c;

  assign tick_wrap_c = (tick_cnt == LAST_TICK);
  assign frame_end_c = tick_wrap_c && (idx == LAST_IDX);

  // Scan prescaler, digit index, frame counter and blink phase.
  always_ff @(posedge clk) begin
    if (reset) begin
      tick_cnt    <= '0;
      idx         <= '0;
      frame_cnt   <= '0;
      blink_phase <= 1'b0;
    end else if (tick_wrap_c) begin
      tick_cnt <= '0;
      idx      <= (idx == LAST_IDX) ? '0 : idx + IDX_W'(1);
      if (frame_end_c) begin
        if (frame_cnt == LAST_FRAME) begin
          frame_cnt   <= '0;
          blink_phase <= ~blink_phase;
        end else begin
          frame_cnt <= frame_cnt + FRAME_W'(1);
        end
      end
    end else begin
      tick_cnt <= tick_cnt + TICK_W'(1);
    end
  end

  // Pending/active buffers; a load coinciding with a frame boundary bypasses pending.
  always_ff @(posedge clk) begin
    if (reset) begin
      act_value  <= '0;
      act_blank  <= '0;
      act_blink  <= '0;
      pend_value <= '0;
      pend_blank <= '0;
      pend_blink <= '0;
      pending    <= 1'b0;
    end else if (load && frame_end_c) begin
      act_value <= value;
      act_blank <= blank;
      act_blink <= blink;
      pending   <= 1'b0;
    end else if (load) begin
      pend_value <= value;
      pend_blank <= blank;
      pend_blink <= blink;
      pending    <= 1'b1;
    end else if (frame_end_c && pending) begin
      act_value <= pend_value;
      act_blank <= pend_blank;
      act_blink <= pend_blink;
      pending   <= 1'b0;
    end
  end

  // Leading-zero mask: zero nibbles from the top digit down to the first non-zero one.
  always_comb begin
    logic run;
    run       = 1'b1;
    lz_mask_c = '0;
    for (int i = int'(NUM_DIGITS) - 1; i >= 0; i--) begin
      run          = run & (act_value[4*i +: 4] == 4'h0);
      lz_mask_c[i] = lz_en & run & (i != 0);
    end
  end

  // Select the current digit's nibble, off condition and anode pattern.
  always_comb begin
    nibble_c = 4'h0;
    dark_c   = 1'b1;
    an_c     = '1;
    for (int i = 0; i < int'(NUM_DIGITS); i++) begin
      if (idx == IDX_W'(i)) begin
        nibble_c = act_value[4*i +: 4];
        dark_c   = act_blank[i] | (act_blink[i] & blink_phase) | lz_mask_c[i];
        an_c[i]  = 1'b0;
      end
    end
  end

  hex_to_seg u_hex_to_seg (
    .nibble  (nibble_c),
    .glyph_c (glyph_c)
  );

  // Registered pin drive; dark digits keep their anode low to keep duty uniform.
  always_ff @(posedge clk) begin
    if (reset) begin
      seg <= SEG_OFF;
      an  <= '1;
    end else begin
      seg <= dark_c ? SEG_OFF : glyph_c;
      an  <= an_c;
    end
  end

endmodule

// File: tb/tb_seg_scan_display.sv
// Directed bench for seg_scan_display with NUM_DIGITS=4, TICKS_PER_DIGIT=4, BLINK_FRAMES=2.
module tb_seg_scan_display;

  logic        clk;
  logic        reset;
  logic [15:0] value;
  logic [3:0]  blank;
  logic [3:0]  blink;
  logic        lz_en;
  logic        load;
  logic        pending;
  logic [6:0]  seg;
  logic [3:0]  an;

  int          vecs;
  int          errs;
  int          k;
  logic [6:0]  exp_seg [4];
  logic        exp_pend;

  seg_scan_display #(
    .NUM_DIGITS      (4),
    .TICKS_PER_DIGIT (4),
    .BLINK_FRAMES    (2)
  ) dut (
    .clk     (clk),
    .reset   (reset),
    .value   (value),
    .blank   (blank),
    .blink   (blink),
    .lz_en   (lz_en),
    .load    (load),
    .pending (pending),
    .seg     (seg),
    .an      (an)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    vecs++;
    assert (obs === expv) else begin
      errs++;
      $error("FAIL %s (edge %0d): observed %h expected %h", tag, k, obs, expv);
    end
  endtask

  // Advance n clock edges, checking the scan position, glyph and pending flag after each.
  task automatic run_edges(input int n);
    int d;
    logic [3:0] ea;
    for (int j = 0; j < n; j++) begin
      @(posedge clk);
      #1;
      k++;
      d  = ((k - 1) / 4) % 4;
      ea = ~(4'b0001 << d);
      chk("an", 32'(an), 32'(ea));
      chk("seg", 32'(seg), 32'(exp_seg[d]));
      chk("pending", 32'(pending), 32'(exp_pend));
    end
  endtask

  task automatic set_all(input logic [6:0] g);
    for (int i = 0; i < 4; i++) exp_seg[i] = g;
  endtask

  initial begin
    vecs     = 0;
    errs     = 0;
    k        = 0;
    reset    = 1'b1;
    value    = 16'h0000;
    blank    = 4'b0000;
    blink    = 4'b0000;
    lz_en    = 1'b0;
    load     = 1'b0;
    exp_pend = 1'b0;
    set_all(7'h40);

    // Reset values
    repeat (3) @(posedge clk);
    #1;
    chk("rst_an", 32'(an), 32'h0000000F);
    chk("rst_seg", 32'(seg), 32'h0000007F);
    chk("rst_pending", 32'(pending), 32'h0);

    // Reset/scan: two full frames of "0000"
    reset = 1'b0;
    run_edges(32);

    // Double buffering: mid-frame load of 12AF
    run_edges(6);
    value = 16'h12AF; load = 1'b1; exp_pend = 1'b1;
    run_edges(1);
    load = 1'b0;
    run_edges(8);
    exp_pend = 1'b0;
    run_edges(1);
    exp_seg[0] = 7'h0E; exp_seg[1] = 7'h08; exp_seg[2] = 7'h24; exp_seg[3] = 7'h79;
    run_edges(16);

    // Load exactly on the boundary cycle: no pending pulse
    run_edges(15);
    value = 16'h3456; load = 1'b1;
    run_edges(1);
    load = 1'b0;
    exp_seg[0] = 7'h02; exp_seg[1] = 7'h12; exp_seg[2] = 7'h19; exp_seg[3] = 7'h30;
    run_edges(16);

    // Back-to-back loads within one frame: only 2222 shows
    run_edges(2);
    value = 16'h1111; load = 1'b1; exp_pend = 1'b1;
    run_edges(1);
    load = 1'b0;
    run_edges(2);
    value = 16'h2222; load = 1'b1;
    run_edges(1);
    load = 1'b0;
    run_edges(9);
    exp_pend = 1'b0;
    run_edges(1);
    set_all(7'h24);
    run_edges(16);

    // Leading-zero suppression on 0050
    run_edges(2);
    value = 16'h0050; lz_en = 1'b1; load = 1'b1; exp_pend = 1'b1;
    run_edges(1);
    load = 1'b0;
    run_edges(12);
    exp_pend = 1'b0;
    run_edges(1);
    exp_seg[0] = 7'h40; exp_seg[1] = 7'h12; exp_seg[2] = 7'h7F; exp_seg[3] = 7'h7F;
    run_edges(16);

    // Blank digit 0
    run_edges(2);
    blank = 4'b0001; load = 1'b1; exp_pend = 1'b1;
    run_edges(1);
    load = 1'b0;
    run_edges(12);
    exp_pend = 1'b0;
    run_edges(1);
    exp_seg[0] = 7'h7F;
    run_edges(16);

    // Blink digit 1 on 4321; lz_en drop acts on the live display at once
    run_edges(2);
    value = 16'h4321; blank = 4'b0000; blink = 4'b0010; lz_en = 1'b0;
    load = 1'b1; exp_pend = 1'b1;
    exp_seg[2] = 7'h40; exp_seg[3] = 7'h40;
    run_edges(1);
    load = 1'b0;
    run_edges(12);
    exp_pend = 1'b0;
    run_edges(1);
    exp_seg[0] = 7'h79; exp_seg[1] = 7'h24; exp_seg[2] = 7'h30; exp_seg[3] = 7'h19;
    run_edges(16);
    exp_seg[1] = 7'h7F;
    run_edges(32);
    exp_seg[1] = 7'h24;
    run_edges(32);
    exp_seg[1] = 7'h7F;
    run_edges(16);

    // Reset while an update is pending
    run_edges(2);
    value = 16'h9999; blink = 4'b0000; load = 1'b1; exp_pend = 1'b1;
    run_edges(1);
    load = 1'b0;
    reset = 1'b1;
    @(posedge clk);
    #1;
    chk("midrst_an", 32'(an), 32'h0000000F);
    chk("midrst_seg", 32'(seg), 32'h0000007F);
    chk("midrst_pending", 32'(pending), 32'h0);
    reset = 1'b0;
    k = 0;
    exp_pend = 1'b0;
    set_all(7'h40);
    run_edges(32);

    // Remaining glyphs: 789B via pending, then CDE0 on the boundary
    run_edges(2);
    value = 16'h789B; load = 1'b1; exp_pend = 1'b1;
    run_edges(1);
    load = 1'b0;
    run_edges(12);
    exp_pend = 1'b0;
    run_edges(1);
    exp_seg[0] = 7'h03; exp_seg[1] = 7'h10; exp_seg[2] = 7'h00; exp_seg[3] = 7'h78;
    run_edges(16);
    run_edges(15);
    value = 16'hCDE0; load = 1'b1;
    run_edges(1);
    load = 1'b0;
    exp_seg[0] = 7'h40; exp_seg[1] = 7'h06; exp_seg[2] = 7'h21; exp_seg[3] = 7'h46;
    run_edges(16);

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
